maxmin_sched: RTL and testbench
===============================

// Module: maxmin_sched
// PURPOSE
//  Shares one running max/min accumulator between NREQ requesters.
//  Picks one requester at a time, round-robin, and grants it. Accepts LEN samples
//  from that requester, then returns max, min and requester id with a one-cycle
//  out_valid pulse. Sits between the sample sources and the result consumer.
// PARAMETERS
//  NREQ    4   number of requesters (>=2); IDW = $clog2(NREQ) derived
//  DATA_W  8   sample width (unsigned)
//  LEN     15  samples per burst (>=1)
// PORTS
//  clk        in   1            single clock, all logic on posedge
//  rst        in   1            synchronous, active-high reset
//  req        in   NREQ         requester i wants a burst; held until out_valid or abort
//  in_valid   in   NREQ         per-requester sample strobe
//  in_num     in   NREQ*DATA_W  packed samples; requester i at [i*DATA_W +: DATA_W]
//  gnt        out  NREQ         one-hot grant, registered
//  out_valid  out  1            one-cycle result pulse
//  out_max    out  DATA_W       burst maximum
//  out_min    out  DATA_W       burst minimum
//  out_id     out  IDW          index of the requester that owns the result
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, gnt=0, out_valid=0, out_max=0,
//   out_min={DATA_W{1'b1}}, out_id=0, count=0, rr pointer=NREQ-1 (req[0] wins first).
//   Reset mid-burst discards the burst. No out_valid is produced for it.
//  FSM states: IDLE, STREAM, DONE.
//   IDLE: if |req, choose the first set req after the rr pointer (wrapping).
//    Next cycle: STREAM, gnt=onehot(winner), acc_max=0, acc_min=all-ones, count=0.
//    If no req, stay in IDLE with gnt=0.
//   STREAM: a sample is accepted only when gnt[i] && in_valid[i].
//    in_valid from ungranted requesters is ignored.
//    in_valid gaps (stalls) are allowed and there is no timeout.
//    On accept: acc_max=max(acc_max,x), acc_min=min(acc_min,x), count++.
//    Compares are unsigned, and equal values leave the accumulator unchanged.
//    On the accept that makes count==LEN: next cycle DONE.
//   DONE (exactly 1 cycle): out_valid=1, gnt=0, out_max/out_min=final accumulators,
//    out_id=winner, rr pointer=winner. Next cycle: IDLE.
//  Latency: out_valid is 1 cycle after the LEN-th accepted sample.
//   The next gnt is no earlier than 2 cycles after out_valid (DONE -> IDLE -> STREAM).
//  Abort: req[winner]==0 during STREAM ends the burst.
//   Next cycle: IDLE, gnt=0, no out_valid; outputs keep their previous values.
//   rr pointer=winner. A sample accepted in the abort cycle is discarded.
//  out_max/out_min/out_id hold their last values between pulses. They are
//   meaningful only while out_valid=1.
//  LEN=1: a single sample gives out_max==out_min==sample.
//  Simultaneous requests are resolved by rr order only; no requester waits more
//   than NREQ-1 bursts.
//  count width is $clog2(LEN+1). count never wraps.
// STRUCTURE
//  maxmin_pkg: state_t enum {IDLE,STREAM,DONE}, DATA_W default, MAXV/MINV init
//   constants.
//  Sub-module rr_arbiter #(NREQ): inputs req and last pointer; outputs one-hot
//   winner and its index. Purely combinational.
//  The top holds the FSM, counter, input mux and accumulators.
// TESTING
//  1 req[0] only, LEN=15, samples 5,200,17,9,...,(all others in 6..199)
//    -> gnt=0001 the cycle after req; out_valid 1 cycle after the 15th accept;
//       out_max=200, out_min=5, out_id=0; out_valid high for exactly 1 cycle.
//  2 req=1111 held from reset, each requester streams its burst
//    -> grant order 0,1,2,3, four out_valid pulses with out_id 0,1,2,3.
//    Then req 0 and 3 together -> 0 granted before 3.
//  3 Granted req[1] with random in_valid gaps; req[2] pulses in_valid with 8'h00
//    and 8'hFF while ungranted -> result matches req[1] data only; count ignores gaps.
//  4 req[2] drops after 7 accepted samples -> gnt=0 next cycle, no out_valid.
//    A pending req[3] is granted 1 cycle later.
//  5 rst=1 for one cycle mid-STREAM -> next cycle gnt=0, out_valid=0, out_max=0,
//    out_min=8'hFF. After release req[0] wins first.
//  6 Extremes: all samples 8'hFF -> max=min=FF; all 8'h00 -> max=min=00.
//    LEN=1 build: single sample 8'h42 -> max=min=42.

Source files
------------

// File: rtl/maxmin_pkg.sv
// maxmin_pkg
//   Shared definitions for the max/min burst scheduler: FSM state encoding,
//   default sample width and the fill bits used to initialise the running
//   maximum (all zeros) and running minimum (all ones) accumulators.
package maxmin_pkg;

  // Raw state codes, kept as plain constants for code that predates the enum
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_STREAM = 2'b01;
  localparam logic [1:0] ST_DONE   = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    STREAM = ST_STREAM,
    DONE   = ST_DONE
  } state_t;

  localparam int DEF_DATA_W = 8;

  // Any sample beats the max seed and undercuts the min seed
  localparam logic MAXV_INIT_BIT = 1'b0;
  localparam logic MINV_INIT_BIT = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: searches req starting at the position just
//   after last_ptr (wrapping) and returns the first set request.
// Ports
//   req       in  NREQ   request vector
//   last_ptr  in  IDW    index of the most recently served requester
//   win_oh    out NREQ   one-hot winner (all zeros when req==0)
//   win_idx   out IDW    index of the winner (0 when req==0)
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_ptr,
  output logic [NREQ-1:0]         win_oh,
  output logic [$clog2(NREQ)-1:0] win_idx
);

  localparam int IDW = $clog2(NREQ);

  // Walk every position once, starting after last_ptr; first hit wins
  always_comb begin
    int                 pos_v;
    logic [IDW-1:0]     pos_s;
    logic               found_s;
    logic               hit_s;
    win_oh  = {NREQ{1'b0}};
    win_idx = {IDW{1'b0}};
    found_s = 1'b0;
    pos_v   = 0;
    pos_s   = {IDW{1'b0}};
    hit_s   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      pos_v          = (int'(last_ptr) + k) % NREQ;
      pos_s          = pos_v[IDW-1:0];
      hit_s          = (!found_s) && req[pos_s];
      win_oh[pos_s]  = hit_s;
      win_idx        = hit_s ? pos_s : win_idx;
      found_s        = found_s | hit_s;
    end
  end

endmodule

// File: rtl/maxmin_sched.sv
// maxmin_sched
//   Shares one running max/min accumulator between NREQ requesters. A
//   round-robin pick grants one requester, LEN samples are taken from it, and
//   the burst max, min and owner id are presented with a one-cycle out_valid.
//   Dropping the owner's req mid-burst abandons the burst without a result.
// Ports
//   clk        in   1            clock, all state on posedge
//   rst        in   1            synchronous active-high reset
//   req        in   NREQ         requester i wants a burst
//   in_valid   in   NREQ         per-requester sample strobe
//   in_num     in   NREQ*DATA_W  packed samples, requester i at [i*DATA_W +: DATA_W]
//   gnt        out  NREQ         registered one-hot grant
//   out_valid  out  1            one-cycle result pulse
//   out_max    out  DATA_W       burst maximum
//   out_min    out  DATA_W       burst minimum
//   out_id     out  IDW          owner of the result
module maxmin_sched
  import maxmin_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          in_valid,
  input  logic [NREQ*DATA_W-1:0]   in_num,
  output logic [NREQ-1:0]          gnt,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_max,
  output logic [DATA_W-1:0]        out_min,
  output logic [$clog2(NREQ)-1:0]  out_id
);

  localparam int IDW   = $clog2(NREQ);
  localparam int CNT_W = $clog2(LEN + 1);

  localparam logic [DATA_W-1:0] MAX_INIT = {DATA_W{MAXV_INIT_BIT}};
  localparam logic [DATA_W-1:0] MIN_INIT = {DATA_W{MINV_INIT_BIT}};
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LEN - 1);

  state_t              state_r;
  logic [NREQ-1:0]     gnt_r;
  logic [IDW-1:0]      own_r;
  logic [IDW-1:0]      rr_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [DATA_W-1:0]   acc_max_r;
  logic [DATA_W-1:0]   acc_min_r;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_max_r;
  logic [DATA_W-1:0]   out_min_r;
  logic [IDW-1:0]      out_id_r;

  logic [NREQ-1:0]     arb_oh_s;
  logic [IDW-1:0]      arb_idx_s;
  logic                sel_valid_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                own_req_s;
  logic [DATA_W-1:0]   nxt_max_s;
  logic [DATA_W-1:0]   nxt_min_s;
  logic                last_s;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req      (req),
    .last_ptr (rr_ptr_r),
    .win_oh   (arb_oh_s),
    .win_idx  (arb_idx_s)
  );

  // Route the owner's strobe, sample and request; strobe is also gated by gnt
  // so nothing is accepted outside STREAM
  always_comb begin
    sel_valid_s = 1'b0;
    sel_data_s  = {DATA_W{1'b0}};
    own_req_s   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_valid_s = (own_r == IDW'(i)) ? (gnt_r[i] & in_valid[i])       : sel_valid_s;
      sel_data_s  = (own_r == IDW'(i)) ? in_num[i*DATA_W +: DATA_W]     : sel_data_s;
      own_req_s   = (own_r == IDW'(i)) ? req[i]                         : own_req_s;
    end
  end

  // Unsigned running extremes; ties keep the current value
  always_comb begin
    nxt_max_s = (sel_data_s > acc_max_r) ? sel_data_s : acc_max_r;
    nxt_min_s = (sel_data_s < acc_min_r) ? sel_data_s : acc_min_r;
    last_s    = (count_r == LAST_CNT);
  end

  // Scheduler FSM, counter, accumulators and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      gnt_r       <= {NREQ{1'b0}};
      own_r       <= {IDW{1'b0}};
      rr_ptr_r    <= IDW'(NREQ - 1);
      count_r     <= {CNT_W{1'b0}};
      acc_max_r   <= MAX_INIT;
      acc_min_r   <= MIN_INIT;
      out_valid_r <= 1'b0;
      out_max_r   <= MAX_INIT;
      out_min_r   <= MIN_INIT;
      out_id_r    <= {IDW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (|req) begin
            state_r   <= STREAM;
            gnt_r     <= arb_oh_s;
            own_r     <= arb_idx_s;
            acc_max_r <= MAX_INIT;
            acc_min_r <= MIN_INIT;
            count_r   <= {CNT_W{1'b0}};
          end else begin
            gnt_r     <= {NREQ{1'b0}};
          end
        end
        STREAM: begin
          out_valid_r <= 1'b0;
          // Abort wins over a same-cycle sample, which is thrown away
          if (!own_req_s) begin
            state_r  <= IDLE;
            gnt_r    <= {NREQ{1'b0}};
            rr_ptr_r <= own_r;
          end else if (sel_valid_s) begin
            acc_max_r <= nxt_max_s;
            acc_min_r <= nxt_min_s;
            count_r   <= count_r + CNT_W'(1);
            if (last_s) begin
              // Result is loaded on entry so it is visible during DONE
              state_r     <= DONE;
              gnt_r       <= {NREQ{1'b0}};
              out_valid_r <= 1'b1;
              out_max_r   <= nxt_max_s;
              out_min_r   <= nxt_min_s;
              out_id_r    <= own_r;
              rr_ptr_r    <= own_r;
            end else begin
              state_r     <= STREAM;
            end
          end else begin
            state_r <= STREAM;
          end
        end
        DONE: begin
          out_valid_r <= 1'b0;
          gnt_r       <= {NREQ{1'b0}};
          state_r     <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          gnt_r       <= {NREQ{1'b0}};
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign out_valid = out_valid_r;
  assign out_max   = out_max_r;
  assign out_min   = out_min_r;
  assign out_id    = out_id_r;

endmodule

// File: tb/tb_maxmin_sched.sv
// tb_maxmin_sched
//   Directed bench for maxmin_sched. Stimulus pushes the hand-computed burst
//   result into a queue; a negedge monitor pops and compares on every
//   out_valid. A second instance built with LEN=1 covers single-sample bursts.
module tb_maxmin_sched;

  localparam int LEN = 15;

  typedef struct packed {
    logic [7:0] mx;
    logic [7:0] mn;
    logic [1:0] id;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  in_valid;
  logic [7:0]  num_a [4];
  logic [31:0] in_num;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [7:0]  out_max;
  logic [7:0]  out_min;
  logic [1:0]  out_id;

  logic [3:0]  req1;
  logic [3:0]  in_valid1;
  logic [31:0] in_num1;
  logic [3:0]  gnt1;
  logic        out_valid1;
  logic [7:0]  out_max1;
  logic [7:0]  out_min1;
  logic [1:0]  out_id1;

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q  [$];
  res_t exp1_q [$];
  res_t mon_e;
  res_t mon1_e;
  int   smp [15];
  bit   noise_en = 1'b0;
  int   noise_cyc = 0;

  assign in_num = {num_a[3], num_a[2], num_a[1], num_a[0]};

  always #5 clk = ~clk;

  maxmin_sched #(.NREQ(4), .DATA_W(8), .LEN(LEN)) u_dut (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_num(in_num),
    .gnt(gnt), .out_valid(out_valid), .out_max(out_max), .out_min(out_min),
    .out_id(out_id)
  );

  maxmin_sched #(.NREQ(4), .DATA_W(8), .LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .in_valid(in_valid1), .in_num(in_num1),
    .gnt(gnt1), .out_valid(out_valid1), .out_max(out_max1), .out_min(out_min1),
    .out_id(out_id1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] mx, input logic [7:0] mn, input logic [1:0] id);
    res_t r;
    r.mx = mx; r.mn = mn; r.id = id;
    exp_q.push_back(r);
  endtask

  // Ungranted requester 2 flips between 00 and FF samples with a strobe
  task automatic drive_noise();
    if (noise_en) begin
      noise_cyc++;
      in_valid[2] = noise_cyc[0];
      num_a[2]    = noise_cyc[1] ? 8'hFF : 8'h00;
    end
  endtask

  task automatic wait_gnt(input logic [1:0] id);
    for (int i = 0; i < 32 && gnt == 4'b0000; i++) tick();
    chk("gnt_onehot", {28'd0, gnt}, {28'd0, 4'b0001 << id});
  endtask

  task automatic stream(input logic [1:0] id, input int n, input int gap_max);
    for (int j = 0; j < n; j++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid[id] = 1'b0;
        num_a[id]    = 8'hFF;
        drive_noise();
        tick();
      end
      in_valid[id] = 1'b1;
      num_a[id]    = 8'(smp[j]);
      drive_noise();
      tick();
    end
    in_valid[id] = 1'b0;
  endtask

  task automatic serve(input logic [1:0] id, input logic [7:0] mx, input logic [7:0] mn,
                       input int gap_max, input logic [3:0] drop);
    wait_gnt(id);
    push_exp(mx, mn, id);
    stream(id, LEN, gap_max);
    chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
    chk("gnt_clear_done", {28'd0, gnt}, 32'd0);
    req = req & ~drop;
    tick();
    chk("out_valid_pulse", {31'd0, out_valid}, 32'd0);
  endtask

  // Scoreboard monitor for the LEN=15 instance
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result actual id=%0d max=%0h min=%0h required none", out_id, out_max, out_min);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_max", {24'd0, out_max}, {24'd0, mon_e.mx});
        chk("sb_min", {24'd0, out_min}, {24'd0, mon_e.mn});
        chk("sb_id",  {30'd0, out_id},  {30'd0, mon_e.id});
      end
    end
  end

  // Scoreboard monitor for the LEN=1 instance
  always @(negedge clk) begin
    if (out_valid1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result_len1 actual id=%0d max=%0h required none", out_id1, out_max1);
      end else begin
        mon1_e = exp1_q.pop_front();
        chk("sb1_max", {24'd0, out_max1}, {24'd0, mon1_e.mx});
        chk("sb1_min", {24'd0, out_min1}, {24'd0, mon1_e.mn});
        chk("sb1_id",  {30'd0, out_id1},  {30'd0, mon1_e.id});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r1;
    rst = 1'b1; req = 4'b0000; in_valid = 4'b0000;
    for (int i = 0; i < 4; i++) num_a[i] = 8'h00;
    req1 = 4'b0000; in_valid1 = 4'b0000; in_num1 = 32'h0;
    tick(); tick();
    chk("rst_gnt",   {28'd0, gnt},       32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_max",   {24'd0, out_max},   32'h00);
    chk("rst_min",   {24'd0, out_min},   32'hFF);
    chk("rst_id",    {30'd0, out_id},    32'd0);
    rst = 1'b0;

    // 1: single requester, grant one cycle after req
    req = 4'b0001;
    tick();
    chk("t1_gnt_next", {28'd0, gnt}, 32'b0001);
    smp = '{5, 200, 17, 9, 50, 60, 70, 80, 90, 100, 110, 120, 130, 140, 199};
    serve(2'd0, 8'd200, 8'd5, 0, 4'b0001);

    // 2: all four requesting from reset -> 0,1,2,3
    req = 4'b1111;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    smp = '{10, 3, 27, 44, 8, 19, 33, 2, 41, 15, 6, 38, 29, 12, 20};
    serve(2'd0, 8'd44, 8'd2, 0, 4'b0000);
    smp = '{100, 150, 120, 101, 149, 130, 111, 140, 125, 115, 145, 105, 135, 110, 102};
    serve(2'd1, 8'd150, 8'd100, 0, 4'b0000);
    smp = '{77, 77, 77, 80, 76, 77, 78, 79, 77, 77, 77, 77, 77, 77, 77};
    serve(2'd2, 8'd80, 8'd76, 0, 4'b0000);
    req = 4'b1001;
    smp = '{255, 0, 128, 64, 32, 16, 8, 4, 2, 1, 127, 63, 31, 15, 7};
    serve(2'd3, 8'd255, 8'd0, 0, 4'b0000);
    // req 0 and 3 together after 3 was served: 0 first, then 3
    smp = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    serve(2'd0, 8'd15, 8'd1, 0, 4'b0000);
    smp = '{60, 61, 62, 63, 64, 65, 66, 67, 68, 69, 70, 71, 72, 73, 59};
    serve(2'd3, 8'd73, 8'd59, 0, 4'b1001);

    // 3: requester 1 with gaps, requester 2 strobing 00/FF while ungranted
    req = 4'b0010;
    noise_en = 1'b1;
    smp = '{30, 90, 45, 77, 61, 12, 99, 50, 88, 23, 70, 33, 64, 41, 57};
    serve(2'd1, 8'd99, 8'd12, 3, 4'b0010);
    noise_en = 1'b0; in_valid[2] = 1'b0; num_a[2] = 8'h00;

    // 4: requester 2 aborts after 7 samples, pending 3 granted next
    req = 4'b1100;
    wait_gnt(2'd2);
    smp = '{250, 251, 1, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0};
    stream(2'd2, 7, 0);
    req[2] = 1'b0; in_valid[2] = 1'b1; num_a[2] = 8'hEE;
    tick();
    chk("t4_abort_gnt",   {28'd0, gnt},       32'd0);
    chk("t4_abort_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_hold_max",    {24'd0, out_max},   32'd99);
    chk("t4_hold_min",    {24'd0, out_min},   32'd12);
    chk("t4_hold_id",     {30'd0, out_id},    32'd1);
    in_valid[2] = 1'b0;
    tick();
    chk("t4_next_gnt", {28'd0, gnt}, 32'b1000);
    smp = '{90, 80, 70, 60, 50, 45, 55, 65, 75, 85, 95, 42, 48, 52, 58};
    serve(2'd3, 8'd95, 8'd42, 1, 4'b1000);

    // 5: reset mid-stream, then requester 0 wins first
    req = 4'b0010;
    wait_gnt(2'd1);
    smp = '{1, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    stream(2'd1, 5, 0);
    rst = 1'b1;
    tick();
    chk("t5_gnt",   {28'd0, gnt},       32'd0);
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_max",   {24'd0, out_max},   32'h00);
    chk("t5_min",   {24'd0, out_min},   32'hFF);
    rst = 1'b0;
    req = 4'b0011;
    tick();
    chk("t5_first_gnt", {28'd0, gnt}, 32'b0001);

    // 6: extremes
    for (int j = 0; j < 15; j++) smp[j] = 255;
    serve(2'd0, 8'hFF, 8'hFF, 0, 4'b0001);
    for (int j = 0; j < 15; j++) smp[j] = 0;
    serve(2'd1, 8'h00, 8'h00, 0, 4'b0010);

    // LEN=1 instance: one sample is both max and min
    req1 = 4'b0001;
    tick();
    chk("len1_gnt0", {28'd0, gnt1}, 32'b0001);
    r1.mx = 8'h42; r1.mn = 8'h42; r1.id = 2'd0; exp1_q.push_back(r1);
    in_valid1[0] = 1'b1; in_num1[7:0] = 8'h42;
    tick();
    chk("len1_valid0", {31'd0, out_valid1}, 32'd1);
    in_valid1 = 4'b0000; req1 = 4'b0000;
    tick();
    chk("len1_pulse0", {31'd0, out_valid1}, 32'd0);
    req1 = 4'b0100;
    tick();
    chk("len1_gnt2", {28'd0, gnt1}, 32'b0100);
    r1.mx = 8'h9C; r1.mn = 8'h9C; r1.id = 2'd2; exp1_q.push_back(r1);
    in_valid1[2] = 1'b1; in_num1[23:16] = 8'h9C;
    tick();
    chk("len1_valid2", {31'd0, out_valid1}, 32'd1);
    in_valid1 = 4'b0000; req1 = 4'b0000;
    tick(); tick();

    chk("sb_drained",  exp_q.size(),  32'd0);
    chk("sb1_drained", exp1_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
